// File: rtl/yu_rom_pkg.sv
// yu_rom_pkg: shared types, port indices and the address check for the ROM arbiter
package yu_rom_pkg;

    typedef enum logic {IDLE, HOLD} rsp_state_t;

    localparam int PORT_IFU = 0;
    localparam int PORT_LSU = 1;

    // Misaligned word access or word index beyond the populated ROM
    function automatic logic rom_addr_err(input logic [63:0] addr, input logic [63:0] size);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= size);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin arbiter; the pointer names the preferred port on a tie
module rr_arbiter_2
    import yu_rom_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] elig,
    input  logic       adv,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    // Grant the sole eligible port, or the pointed one on a tie; after a grant prefer the loser
    always_comb begin
        gnt[PORT_IFU] = elig[PORT_IFU] & (~elig[PORT_LSU] | ~ptr_q);
        gnt[PORT_LSU] = elig[PORT_LSU] & (~elig[PORT_IFU] | ptr_q);
        ptr_d         = adv ? gnt[PORT_IFU] : ptr_q;
    end

    // Pointer register, port 0 preferred out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational ROM between fetch and load ports with registered responses
module rom_arbiter
    import yu_rom_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ROM_SIZE   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic [ADDR_WIDTH-1:0] m0_req_addr,
    output logic                  m0_rsp_valid,
    input  logic                  m0_rsp_ready,
    output logic [DATA_WIDTH-1:0] m0_rsp_data,
    output logic                  m0_rsp_err,
    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic [ADDR_WIDTH-1:0] m1_req_addr,
    output logic                  m1_rsp_valid,
    input  logic                  m1_rsp_ready,
    output logic [DATA_WIDTH-1:0] m1_rsp_data,
    output logic                  m1_rsp_err,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data
);

    logic [1:0]            req_valid;
    logic [1:0]            rsp_ready;
    logic [1:0]            elig;
    logic [1:0]            gnt;
    logic [ADDR_WIDTH-1:0] req_addr [2];
    logic                  rom_err;
    rsp_state_t            state_q  [2];
    rsp_state_t            state_d  [2];
    logic [DATA_WIDTH-1:0] data_q   [2];
    logic [DATA_WIDTH-1:0] data_d   [2];
    logic                  err_q    [2];
    logic                  err_d    [2];

    assign req_valid          = {m1_req_valid, m0_req_valid};
    assign rsp_ready          = {m1_rsp_ready, m0_rsp_ready};
    assign req_addr[PORT_IFU] = m0_req_addr;
    assign req_addr[PORT_LSU] = m1_req_addr;

    // A port may compete only if its buffer is free or being drained this cycle; nothing is granted in reset
    always_comb begin
        elig = '0;
        for (int i = 0; i < 2; i++)
            elig[i] = ~rst & req_valid[i] & ((state_q[i] == IDLE) | rsp_ready[i]);
    end

    rr_arbiter_2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .elig (elig),
        .adv  (|gnt),
        .gnt  (gnt)
    );

    // Route the winner's address to the ROM and classify it
    always_comb begin
        rom_addr = gnt[PORT_IFU] ? req_addr[PORT_IFU] : gnt[PORT_LSU] ? req_addr[PORT_LSU] : '0;
        rom_err  = rom_addr_err(64'(rom_addr), 64'(ROM_SIZE));
    end

    // Per-port buffer: capture on grant, free on consume, otherwise hold the response stable
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = gnt[i] ? HOLD : rsp_ready[i] ? IDLE : state_q[i];
            data_d[i]  = gnt[i] ? (rom_err ? '0 : rom_data) : data_q[i];
            err_d[i]   = gnt[i] ? rom_err : err_q[i];
        end
    end

    // Response FSM and its registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                data_q[i]  <= '0;
                err_q[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                data_q[i]  <= data_d[i];
                err_q[i]   <= err_d[i];
            end
        end
    end

    assign m0_req_ready = gnt[PORT_IFU];
    assign m1_req_ready = gnt[PORT_LSU];
    assign m0_rsp_valid = state_q[PORT_IFU] == HOLD;
    assign m1_rsp_valid = state_q[PORT_LSU] == HOLD;
    assign m0_rsp_data  = data_q[PORT_IFU];
    assign m1_rsp_data  = data_q[PORT_LSU];
    assign m0_rsp_err   = err_q[PORT_IFU];
    assign m1_rsp_err   = err_q[PORT_LSU];

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: randomized scoreboard bench for the two-port ROM arbiter
module tb_rom_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RS = 64;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req_ready, m1_req_ready;
    logic          m0_rsp_valid, m1_rsp_valid;
    logic [DW-1:0] m0_rsp_data, m1_rsp_data;
    logic          m0_rsp_err, m1_rsp_err;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;

    logic [1:0]    drv_v;
    logic [1:0]    drv_r;
    logic [AW-1:0] drv_a [2];
    logic [1:0]    acc;

    logic [DW-1:0] rom_mem [RS];
    rsp_t          exp_q [2][$];
    logic [AW-1:0] plan  [2][$];
    int            p_v [2];
    int            p_r [2];
    int            pref;
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    assign rom_data = rom_mem[rom_addr[7:2]];

    rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_SIZE(RS)) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req_valid (drv_v[0]),
        .m0_req_ready (m0_req_ready),
        .m0_req_addr  (drv_a[0]),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_ready (drv_r[0]),
        .m0_rsp_data  (m0_rsp_data),
        .m0_rsp_err   (m0_rsp_err),
        .m1_req_valid (drv_v[1]),
        .m1_req_ready (m1_req_ready),
        .m1_req_addr  (drv_a[1]),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_ready (drv_r[1]),
        .m1_rsp_data  (m1_rsp_data),
        .m1_rsp_err   (m1_rsp_err),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected response from the address rules alone
    function automatic rsp_t model(input logic [AW-1:0] a);
        rsp_t m;
        m.err  = (a % 4 != 0) || (a / 4 >= RS);
        m.data = m.err ? '0 : rom_mem[a[7:2]];
        return m;
    endfunction

    function automatic logic [AW-1:0] pick();
        int k;
        k = $urandom_range(0, 7);
        return k == 0 ? AW'(6) : k == 1 ? AW'('h100) : k == 2 ? AW'('hFC) :
               k == 3 ? AW'($urandom) : AW'($urandom_range(0, RS - 1) * 4);
    endfunction

    // Monitor: predict grants from eligibility and the turn, check responses against the scoreboard
    always @(negedge clk) begin
        logic [1:0]    v, r, rv, g, el;
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        logic          e [2];
        int            w;
        v = drv_v; r = drv_r;
        rv = {m1_rsp_valid, m0_rsp_valid};
        g = {m1_req_ready, m0_req_ready};
        a[0] = drv_a[0]; a[1] = drv_a[1];
        d[0] = m0_rsp_data; d[1] = m1_rsp_data;
        e[0] = m0_rsp_err; e[1] = m1_rsp_err;
        if (rst) begin
            exp_q[0].delete();
            exp_q[1].delete();
            pref = 0;
            acc = '0;
            chk("rst_req_ready", 64'(g), 64'(0));
            chk("rst_rsp_valid", 64'(rv), 64'(0));
        end else begin
            for (int p = 0; p < 2; p++) el[p] = v[p] && (exp_q[p].size() == 0 || r[p]);
            w = (el[0] && el[1]) ? pref : el[0] ? 0 : el[1] ? 1 : -1;
            chk("grant", 64'(g), 64'(w < 0 ? 0 : (1 << w)));
            chk("rom_addr", 64'(rom_addr), 64'(w < 0 ? '0 : a[w]));
            for (int p = 0; p < 2; p++) begin
                if (rv[p]) begin
                    if (exp_q[p].size() == 0) chk(p ? "m1_spurious_rsp" : "m0_spurious_rsp", 64'(1), 64'(0));
                    else begin
                        chk(p ? "m1_rsp_data" : "m0_rsp_data", 64'(d[p]), 64'(exp_q[p][0].data));
                        chk(p ? "m1_rsp_err" : "m0_rsp_err", 64'(e[p]), 64'(exp_q[p][0].err));
                        if (r[p]) void'(exp_q[p].pop_front());
                    end
                end else chk(p ? "m1_missing_rsp" : "m0_missing_rsp", 64'(exp_q[p].size()), 64'(0));
            end
            if (w >= 0) begin
                exp_q[w].push_back(model(a[w]));
                pref = 1 - w;
            end
            acc = v & g;
        end
    end

    // One cycle of stimulus: hold a pending request, otherwise issue a planned or random one
    task automatic step();
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (!(drv_v[p] && !acc[p])) begin
                if (plan[p].size() != 0) begin
                    drv_v[p] = 1'b1;
                    drv_a[p] = plan[p].pop_front();
                end else begin
                    drv_v[p] = $urandom_range(0, 99) < p_v[p];
                    drv_a[p] = pick();
                end
            end
            drv_r[p] = $urandom_range(0, 99) < p_r[p];
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        for (int i = 0; i < RS; i++) rom_mem[i] = $urandom;
        drv_v = '0; drv_r = '0; drv_a[0] = '0; drv_a[1] = '0; acc = '0; pref = 0;
        p_v[0] = 0; p_v[1] = 0; p_r[0] = 100; p_r[1] = 100;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        // single port streaming
        plan[0].push_back('h0); plan[0].push_back('h4); plan[0].push_back('h8);
        run(6);
        // contention with both responders always ready
        repeat (4) begin plan[0].push_back('h10); plan[1].push_back('h20); end
        run(10);
        // backpressure on port 0 while port 1 streams
        plan[0].push_back('h4);
        p_r[0] = 0; p_v[1] = 100;
        run(8);
        p_r[0] = 100; p_v[1] = 0;
        run(3);
        // error classes on port 1
        plan[1].push_back('h6); plan[1].push_back('h100); plan[1].push_back('hFC);
        run(6);
        // consume and re-request in the same cycle
        plan[0].push_back('h4); plan[0].push_back('h8);
        run(5);
        // random traffic
        for (int ph = 0; ph < 8; ph++) begin
            p_v[0] = $urandom_range(20, 100); p_v[1] = $urandom_range(20, 100);
            p_r[0] = $urandom_range(0, 100);  p_r[1] = $urandom_range(0, 100);
            run(250);
        end
        // asynchronous reset while port 0 holds a response
        p_v[0] = 0; p_v[1] = 60; p_r[0] = 0; p_r[1] = 100;
        run(6);
        plan[0].push_back('hC);
        for (int i = 0; i < 20 && !m0_rsp_valid; i++) step();
        chk("reset_setup_m0_rsp_valid", 64'(m0_rsp_valid), 64'(1));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_m0_rsp_valid", 64'(m0_rsp_valid), 64'(0));
        chk("async_rst_m0_rsp_data", 64'(m0_rsp_data), 64'(0));
        chk("async_rst_m0_req_ready", 64'(m0_req_ready), 64'(0));
        chk("async_rst_m1_req_ready", 64'(m1_req_ready), 64'(0));
        chk("async_rst_rom_addr", 64'(rom_addr), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        p_v[0] = 70; p_r[0] = 80; p_r[1] = 80;
        run(200);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
